pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, sets the payload width in bits.
REQ-002 Parameter SKID, default 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a 1-entry register with combinational in_ready.
REQ-003 Parameter CNT_W, default 16, sets the stall counter width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 clear  input  1  reset: synchronous, active-high.
REQ-006 flush  input  1  synchronous active-high pipeline flush (bubble insertion).
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage can accept a beat this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts the beat this cycle.
REQ-012 out_data  output  DATA_W  downstream payload.
REQ-013 occupancy  output  2  number of held beats, 0..2.
REQ-014 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready; both are evaluated in the same cycle.
REQ-016 Storage: main register M (drives out_data and out_valid); skid register S exists only when SKID=1.
REQ-017 States: EMPTY (occupancy 0), ONE (M valid, occupancy 1), FULL (M and S valid, occupancy 2, SKID=1 only).
REQ-018 EMPTY: input transfer -> ONE, M<=in_data; otherwise hold.
REQ-019 ONE: input and output transfer -> ONE, M<=in_data; input only -> FULL, S<=in_data (SKID=1); output only -> EMPTY; neither -> hold.
REQ-020 FULL: in_ready=0; output transfer -> ONE, M<=S; otherwise hold with M and S unchanged.
REQ-021 SKID=1: in_ready is a register output equal to (next state != FULL); no combinational path exists from out_ready to in_ready.
REQ-022 SKID=0: in_ready = !out_valid | out_ready (combinational); FULL is unreachable.
REQ-023 Latency from input transfer into EMPTY to out_valid=1 is 1 cycle; sustained throughput with out_ready=1 is 1 beat per cycle in both modes.
REQ-024 Beats leave in arrival order with no loss or duplication; out_data holds its value while out_valid=1 and out_ready=0.
REQ-025 flush=1: the next state is EMPTY with out_valid=0, out_data=0 and S=0; any input transfer in the same cycle is discarded; stall_cnt is unaffected.
REQ-026 stall_cnt increments by 1 in each cycle where out_valid=1 and out_ready=0, and saturates at 2^CNT_W-1 (no wrap).
REQ-027 Unused S data bits hold their value when not loaded; M is loaded only on the transitions listed above.

Reset
REQ-028 clear=1 at a rising edge forces, in the next cycle: state EMPTY, out_valid=0, out_data=0, S=0, occupancy=0, stall_cnt=0, in_ready=1.
REQ-029 clear takes priority over flush and over any simultaneous transfer, including when asserted mid-stream in FULL.
REQ-030 After clear deasserts, the first input transfer can occur in the same cycle.

Verification
REQ-031 Clear: clear=1, in_valid=1, in_data=FFFFFFFF for 1 cycle -> out_valid=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1.
REQ-032 Single beat: in_data=AAAAAAAA, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=AAAAAAAA; the following cycle out_valid=0.
REQ-033 Backpressure (SKID=1): out_ready=0, send AAAAAAAA then BBBBBBBB -> occupancy=2, in_ready=0, CCCCCCCC on the input is not taken; then out_ready=1 -> AAAAAAAA, BBBBBBBB, CCCCCCCC on consecutive cycles.
REQ-034 Streaming: out_ready=1, 8 back-to-back beats 0..7 -> outputs 0..7 on consecutive cycles, in_ready never 0; repeat with SKID=0 and get identical results.
REQ-035 Flush in FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=0; the flushed input beat never appears; stall_cnt is retained.
REQ-036 Saturation (CNT_W=4): out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15; clear returns it to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with an optional 2-entry skid buffer and a
// saturating backpressure (stall) counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] s_data;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_m_in;
    logic              load_m_skid;
    logic              load_s;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // NOTE: every register updates with <= so all state samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state and strobes get defaults first so no path infers a latch.
    always_comb begin
        state_next  = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next = ONE;
                    load_m_in  = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_m_in = 1'b1;
                end else if (in_xfer && (SKID != 0)) begin
                    state_next = FULL;
                    load_s     = 1'b1;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_next  = ONE;
                    load_m_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush turns the stage into a bubble and drops any beat offered this cycle.
        if (flush) begin
            state_next  = EMPTY;
            load_m_in   = 1'b0;
            load_m_skid = 1'b0;
            load_s      = 1'b0;
        end
    end

    // NOTE: payload registers are cleared too, so out_data reads zero after clear or flush.
    always_ff @(posedge clk) begin
        if (clear || flush) begin
            m_data <= '0;
            s_data <= '0;
        end else begin
            if (load_m_in) begin
                m_data <= in_data;
            end else if (load_m_skid) begin
                m_data <= s_data;
            end
            if (load_s) begin
                s_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            // Registered ready breaks the out_ready -> in_ready timing path.
            logic ready_q;
            always_ff @(posedge clk) begin
                if (clear) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_next != FULL);
                end
            end
            assign in_ready = ready_q;
        end else begin : g_comb_ready
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    always_comb begin
        out_valid = (state != EMPTY);
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_data = m_data;

endmodule
